// File: rtl/mux_switch_sequencer.sv
// Frame sequencer for the two-level analog mux tree: synchronises the switch strobe,
// steps through data banks, a rotating service slot and a tail slot, then times ADC settling.
module mux_switch_sequencer #(
   parameter int CH_BITS     = 3,
   parameter int BANKS       = 2,
   parameter int BANK_CODE_W = 3,
   parameter int SVC_SLOTS   = 3,
   parameter int TAIL_CODE   = 5,
   parameter int SETTLE      = 4,
   localparam int LAST       = BANKS * (2**CH_BITS) + 1,
   localparam int STEP_W     = $clog2(LAST + 1),
   localparam int SVC_W      = (SVC_SLOTS > 1) ? $clog2(SVC_SLOTS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             switch_in,
   input  logic                             en,
   input  logic                             restart,
   input  logic [SVC_SLOTS*BANK_CODE_W-1:0] svc_code_tbl,
   output logic [CH_BITS-1:0]               addr_lo,
   output logic [BANK_CODE_W-1:0]           bank_code,
   output logic [STEP_W-1:0]                step,
   output logic [SVC_W-1:0]                 svc_idx,
   output logic                             frame_start,
   output logic                             sample_strobe,
   output logic                             overrun
);
   localparam int SVC_STEP = LAST - 1;
   localparam int CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   generate
      if (BANKS + 1 >= 2**BANK_CODE_W || SETTLE == 0) begin : g_cfg_err
         $error("mux_switch_sequencer: illegal BANKS/BANK_CODE_W/SETTLE configuration");
      end
   endgenerate

   typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

   state_t                 state, state_n;
   logic [2:0]             sync_q;
   logic                   adv, load, strobe_n, ovr_n, parked;
   logic [CNT_W-1:0]       cnt;
   logic [STEP_W-1:0]      nxt_step;
   logic [CH_BITS-1:0]     nxt_addr;
   logic [BANK_CODE_W-1:0] nxt_bank;
   logic [SVC_W-1:0]       svc_nxt;

   // sync_q[1] is the synchronised strobe, sync_q[2] its previous value for edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[1:0], switch_in};
   end

   assign adv = en & sync_q[1] & ~sync_q[2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      load     = 1'b0;
      strobe_n = 1'b0;
      ovr_n    = 1'b0;
      if (restart) begin
         state_n = ST_IDLE;
      end else if (adv) begin
         load    = 1'b1;
         ovr_n   = (state == ST_SETTLE);
         state_n = ST_SETTLE;
      end else if (state == ST_SETTLE) begin
         if (!en) begin
            state_n = ST_IDLE;
         end else if (cnt == '0) begin
            strobe_n = 1'b1;
            state_n  = ST_IDLE;
         end
      end
   end

   // Decode of the step about to be loaded; the service code uses the slot not yet consumed
   always_comb begin
      nxt_step = (parked || step == STEP_W'(LAST)) ? '0 : step + 1'b1;
      nxt_addr = '0;
      nxt_bank = '0;
      if (nxt_step < STEP_W'(SVC_STEP)) begin
         nxt_addr = nxt_step[CH_BITS-1:0];
         nxt_bank = BANK_CODE_W'((nxt_step >> CH_BITS) + 1'b1);
      end else if (nxt_step == STEP_W'(SVC_STEP)) begin
         nxt_bank = svc_code_tbl[int'(svc_idx)*BANK_CODE_W +: BANK_CODE_W];
      end else begin
         nxt_addr = CH_BITS'(1);
         nxt_bank = BANK_CODE_W'(TAIL_CODE);
      end
      svc_nxt = (svc_idx == SVC_W'(SVC_SLOTS - 1)) ? '0 : svc_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parked        <= 1'b1;
         step          <= '0;
         addr_lo       <= '0;
         bank_code     <= '0;
         svc_idx       <= '0;
         cnt           <= '0;
         frame_start   <= 1'b0;
         sample_strobe <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         frame_start   <= 1'b0;
         sample_strobe <= strobe_n;
         overrun       <= ovr_n;
         if (restart) begin
            parked    <= 1'b1;
            step      <= '0;
            addr_lo   <= '0;
            bank_code <= '0;
            svc_idx   <= '0;
            cnt       <= '0;
         end else if (load) begin
            parked      <= 1'b0;
            step        <= nxt_step;
            addr_lo     <= nxt_addr;
            bank_code   <= nxt_bank;
            frame_start <= (nxt_step == '0);
            cnt         <= CNT_W'(SETTLE - 1);
            if (!parked && step == STEP_W'(SVC_STEP)) svc_idx <= svc_nxt;
         end else if (state == ST_SETTLE) begin
            if (!en)             cnt <= '0;
            else if (cnt != '0)  cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux_switch_sequencer.sv
// Directed bench for mux_switch_sequencer: a cycle-level frame model checked every cycle,
// plus hand-computed literal expectations along the test plan.
module tb_mux_switch_sequencer;
   localparam int SETTLE = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       switch_in = 1'b0;
   logic       en = 1'b1;
   logic       restart = 1'b0;
   logic [8:0] svc_code_tbl = {3'd6, 3'd4, 3'd3};
   logic [2:0] addr_lo;
   logic [2:0] bank_code;
   logic [4:0] step;
   logic [1:0] svc_idx;
   logic       frame_start, sample_strobe, overrun;

   mux_switch_sequencer dut (
      .clk(clk), .reset(reset), .switch_in(switch_in), .en(en), .restart(restart),
      .svc_code_tbl(svc_code_tbl), .addr_lo(addr_lo), .bank_code(bank_code), .step(step),
      .svc_idx(svc_idx), .frame_start(frame_start), .sample_strobe(sample_strobe),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_str = 0, n_fs = 0, n_ovr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Frame model: samples of switch_in per edge, absolute cycle of the pending strobe
   int cyc = 0;
   bit p1 = 0, p2 = 0, p3 = 0;
   bit m_parked = 1;
   int m_step = 0, m_svc = 0, m_addr = 0, m_bank = 0, strobe_at = -1;
   bit m_fs = 0, m_str = 0, m_ovr = 0;
   int svc_tbl [3] = '{3, 4, 6};

   always @(posedge clk or negedge reset) begin : model
      bit ev, pend, par, fs, st, ov;
      int s, sv, at, a, b;
      if (!reset) begin
         p1 <= 0; p2 <= 0; p3 <= 0;
         m_parked <= 1; m_step <= 0; m_svc <= 0; m_addr <= 0; m_bank <= 0;
         strobe_at <= -1; m_fs <= 0; m_str <= 0; m_ovr <= 0;
      end else begin
         ev = p2 && !p3 && en;
         pend = (strobe_at >= cyc + 1);
         par = m_parked; s = m_step; sv = m_svc; at = strobe_at;
         a = m_addr; b = m_bank; fs = 0; st = 0; ov = 0;
         if (restart) begin
            par = 1; s = 0; sv = 0; a = 0; b = 0; at = -1;
         end else if (ev) begin
            ov = pend;
            if (par) begin
               par = 0; s = 0;
            end else begin
               if (s == 16) sv = (sv + 1) % 3;
               s = (s + 1) % 18;
            end
            fs = (s == 0);
            if (s < 16)       begin a = s % 8; b = s / 8 + 1; end
            else if (s == 16) begin a = 0; b = svc_tbl[sv]; end
            else              begin a = 1; b = 5; end
            at = cyc + 1 + SETTLE;
         end else if (pend && !en) begin
            at = -1;
         end else if (cyc + 1 == at) begin
            st = 1; at = -1;
         end
         cyc <= cyc + 1;
         p3 <= p2; p2 <= p1; p1 <= switch_in;
         m_parked <= par; m_step <= s; m_svc <= sv; m_addr <= a; m_bank <= b;
         strobe_at <= at; m_fs <= fs; m_str <= st; m_ovr <= ov;
      end
   end

   always @(negedge clk) begin : compare
      chk("step", 32'(step), 32'(m_step));
      chk("addr_lo", 32'(addr_lo), 32'(m_addr));
      chk("bank_code", 32'(bank_code), 32'(m_bank));
      chk("svc_idx", 32'(svc_idx), 32'(m_svc));
      chk("frame_start", 32'(frame_start), 32'(m_fs));
      chk("sample_strobe", 32'(sample_strobe), 32'(m_str));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (sample_strobe === 1'b1) n_str++;
      if (frame_start === 1'b1)   n_fs++;
      if (overrun === 1'b1)       n_ovr++;
   end

   task automatic pulse(input int gap);
      @(negedge clk) switch_in = 1'b1;
      repeat (3) @(negedge clk);
      switch_in = 1'b0;
      repeat (gap - 3) @(negedge clk);
   endtask

   int addr_exp [18] = '{0,1,2,3,4,5,6,7,0,1,2,3,4,5,6,7,0,1};
   int bank_exp [18] = '{1,1,1,1,1,1,1,1,2,2,2,2,2,2,2,2,3,5};
   int svc_exp  [3]  = '{4,6,3};

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("rst_step", 32'(step), 0);
      chk("rst_bank", 32'(bank_code), 0);
      chk("rst_pulses", 32'({frame_start, sample_strobe, overrun}), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // first pulse: latency and settle timing by hand
      @(negedge clk) switch_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("lat_before", 32'(bank_code), 0);
      @(negedge clk);
      switch_in = 1'b0;
      chk("lat_bank", 32'(bank_code), 1);
      chk("lat_fs", 32'(frame_start), 1);
      repeat (3) @(negedge clk);
      chk("settle_early", 32'(sample_strobe), 0);
      @(negedge clk);
      chk("settle_strobe", 32'(sample_strobe), 1);
      repeat (13) @(negedge clk);

      for (int i = 1; i < 18; i++) begin
         pulse(20);
         chk("f1_step", 32'(step), 32'(i));
         chk("f1_addr", 32'(addr_lo), 32'(addr_exp[i]));
         chk("f1_bank", 32'(bank_code), 32'(bank_exp[i]));
      end
      chk("f1_fs_count", 32'(n_fs), 1);
      chk("f1_str_count", 32'(n_str), 18);

      k = 0;
      for (int i = 0; i < 54; i++) begin
         pulse(20);
         chk("f2_step", 32'(step), 32'(i % 18));
         if (i % 18 == 16) begin
            chk("svc_bank", 32'(bank_code), 32'(svc_exp[k]));
            k++;
         end
      end
      chk("f2_fs_count", 32'(n_fs), 4);

      // two advances 2 clk apart
      @(negedge clk) switch_in = 1'b1;
      @(negedge clk) switch_in = 1'b0;
      @(negedge clk) switch_in = 1'b1;
      @(negedge clk) switch_in = 1'b0;
      repeat (20) @(negedge clk);
      chk("ovr_step", 32'(step), 1);
      chk("ovr_count", 32'(n_ovr), 1);
      chk("ovr_str_count", 32'(n_str), 73);

      @(negedge clk) en = 1'b0;
      pulse(20);
      chk("dis_step", 32'(step), 1);
      chk("dis_str_count", 32'(n_str), 73);
      en = 1'b1;

      @(negedge clk) switch_in = 1'b1;
      repeat (3) @(negedge clk);
      en = 1'b0;
      switch_in = 1'b0;
      repeat (15) @(negedge clk);
      chk("mid_step", 32'(step), 2);
      chk("mid_str_count", 32'(n_str), 73);
      en = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) pulse(20);
      chk("pre_rst_step", 32'(step), 9);
      @(negedge clk) switch_in = 1'b1;
      repeat (2) @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      switch_in = 1'b0;
      repeat (16) @(negedge clk);
      chk("rs_step", 32'(step), 0);
      chk("rs_bank", 32'(bank_code), 0);
      chk("rs_svc", 32'(svc_idx), 0);
      chk("rs_str_count", 32'(n_str), 80);
      pulse(20);
      chk("rs_next_bank", 32'(bank_code), 1);
      chk("rs_fs_count", 32'(n_fs), 6);

      // asynchronous reset in the middle of settling
      @(negedge clk) switch_in = 1'b1;
      repeat (3) @(negedge clk);
      switch_in = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_step", 32'(step), 0);
      chk("arst_addr", 32'(addr_lo), 0);
      chk("arst_bank", 32'(bank_code), 0);
      chk("arst_pulses", 32'({frame_start, sample_strobe, overrun}), 0);
      repeat (6) @(negedge clk);
      chk("arst_str_count", 32'(n_str), 81);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk) switch_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_before", 32'(bank_code), 0);
      @(negedge clk);
      switch_in = 1'b0;
      chk("post_bank", 32'(bank_code), 1);
      chk("post_fs", 32'(frame_start), 1);
      repeat (10) @(negedge clk);
      chk("post_str_count", 32'(n_str), 82);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
